// File: rtl/uart_pkg.sv
// uart_pkg: shared UART encodings, line-control field positions and oversampling constants
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_state_e;
  localparam int LCR_WLS = 0;
  localparam int LCR_STB = 2;
  localparam int LCR_PEN = 3;
  localparam int LCR_EPS = 4;
  localparam int LCR_SP  = 5;
  localparam logic [1:0] WLS_5 = 2'b00;
  localparam logic [1:0] WLS_6 = 2'b01;
  localparam logic [1:0] WLS_7 = 2'b10;
  localparam logic [1:0] WLS_8 = 2'b11;
  localparam int OVERSAMPLE = 16;
  localparam int MID_SAMPLE = 7;
  // line parity bit for a right-justified, zero-extended character
  function automatic logic parity_bit(input logic [5:0] lcr, input logic [7:0] data);
    return lcr[LCR_SP] ? ~lcr[LCR_EPS] : lcr[LCR_EPS] ? ^data : ~^data;
  endfunction
endpackage

// File: rtl/uart_sync2.sv
// uart_sync2: 2-flop synchronizer resetting to 1 (line idle)
// ports: clk, rst (async, active-high), d (async input), q (synchronized output)
module uart_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic m;
  always_ff @(posedge clk or posedge rst)
    if (rst) {q, m} <= 2'b11;
    else {q, m} <= {m, d};
endmodule

// File: rtl/uart_receiver.sv
// uart_receiver: 16x oversampling UART receive engine pushing characters and error flags to the RX FIFO
// ports: clk, rst (async, active-high), baud_tick (16x enable), sin (serial in), lcr (line control),
//        fifo_full; push, rx_data, pe, fe, bi (valid with push), overrun, rx_busy
module uart_receiver
  import uart_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       baud_tick,
  input  logic       sin,
  input  logic [5:0] lcr,
  input  logic       fifo_full,
  output logic       push,
  output logic [7:0] rx_data,
  output logic       pe,
  output logic       fe,
  output logic       bi,
  output logic       overrun,
  output logic       rx_busy
);
  localparam logic [3:0] LAST_TICK = 4'(OVERSAMPLE - 1);
  localparam logic [3:0] MID_TICK  = 4'(MID_SAMPLE);
  uart_state_e state, state_n;
  logic       sin_s, sin_d, fall, sample, last_bit, stop_done, par_bit, unused_stb;
  logic [3:0] cnt;
  logic [2:0] bit_cnt;
  logic [1:0] wls;
  logic [7:0] shreg, char_data;
  uart_sync2 u_sync (.clk(clk), .rst(rst), .d(sin), .q(sin_s));
  assign wls        = lcr[LCR_WLS +: 2];
  assign unused_stb = lcr[LCR_STB];
  assign fall       = sin_d & ~sin_s;
  // START samples at the bit centre; later bits one full bit period after the previous sample
  assign sample     = baud_tick && cnt == (state == START ? MID_TICK : LAST_TICK);
  assign last_bit   = bit_cnt == {1'b0, wls} + 3'd4;
  assign stop_done  = state == STOP && sample;
  // bits enter at the MSB, so a short character is right-justified by shifting out the stale bits
  assign char_data  = shreg >> (wls == WLS_8 ? 2'd0 : wls == WLS_7 ? 2'd1 : wls == WLS_6 ? 2'd2 : wls == WLS_5 ? 2'd3 : 2'd0);
  assign rx_busy    = state != IDLE;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = fall ? START : IDLE;
      START:   state_n = !sample ? START : sin_s ? IDLE : DATA;
      DATA:    state_n = !(sample && last_bit) ? DATA : lcr[LCR_PEN] ? PARITY : STOP;
      PARITY:  state_n = sample ? STOP : PARITY;
      STOP:    state_n = sample ? IDLE : STOP;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state   <= IDLE;
      sin_d   <= 1'b1;
      cnt     <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      par_bit <= 1'b0;
      push    <= 1'b0;
      overrun <= 1'b0;
      rx_data <= '0;
      pe      <= 1'b0;
      fe      <= 1'b0;
      bi      <= 1'b0;
    end else begin
      state   <= state_n;
      sin_d   <= sin_s;
      cnt     <= state == IDLE ? '0 : !baud_tick ? cnt : (state == START && sample) ? '0 : cnt + 4'd1;
      bit_cnt <= state != DATA ? '0 : sample ? bit_cnt + 3'd1 : bit_cnt;
      if (state == DATA && sample) shreg <= {sin_s, shreg[7:1]};
      // cleared during START so a parity-less frame counts as a zero parity bit for break detection
      par_bit <= state == START ? 1'b0 : (state == PARITY && sample) ? sin_s : par_bit;
      push    <= stop_done && !fifo_full;
      overrun <= stop_done && fifo_full;
      if (stop_done && !fifo_full) begin
        rx_data <= char_data;
        pe      <= lcr[LCR_PEN] && par_bit != parity_bit(lcr, char_data);
        fe      <= ~sin_s;
        bi      <= char_data == 8'h00 && !par_bit && !sin_s;
      end
    end
endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: randomized and directed UART frames checked against a frame-level scoreboard
module tb_uart_receiver;
  logic clk = 0, rst = 1, baud_tick = 0, sin = 1, fifo_full = 0;
  logic [5:0] lcr = 6'b000011;
  logic push, pe, fe, bi, overrun, rx_busy;
  logic [7:0] rx_data;
  int checks = 0, failures = 0;
  int div = 0, tick_cnt = 0;
  bit hold = 0;
  typedef struct {
    logic [7:0] data;
    logic pe, fe, bi, ovr;
    int ticks;
  } exp_t;
  exp_t q[$];
  exp_t mon_e;

  uart_receiver dut (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .sin(sin), .lcr(lcr), .fifo_full(fifo_full),
    .push(push), .rx_data(rx_data), .pe(pe), .fe(fe), .bi(bi), .overrun(overrun), .rx_busy(rx_busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    div = (div == 3) ? 0 : div + 1;
    baud_tick = !hold && div == 0;
  end

  always @(posedge clk)
    if (!rx_busy) tick_cnt = 0;
    else if (baud_tick) tick_cnt = tick_cnt + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk)
    if (!rst && (push || overrun)) begin
      check("event_expected", 32'(q.size() != 0), 32'd1);
      check("push_ovr_excl", 32'(push & overrun), 32'd0);
      if (q.size() != 0) begin
        mon_e = q.pop_front();
        check("overrun", 32'(overrun), 32'(mon_e.ovr));
        check("ticks", 32'(tick_cnt), 32'(mon_e.ticks));
        if (push) begin
          check("rx_data", 32'(rx_data), 32'(mon_e.data));
          check("pe", 32'(pe), 32'(mon_e.pe));
          check("fe", 32'(fe), 32'(mon_e.fe));
          check("bi", 32'(bi), 32'(mon_e.bi));
        end
      end
    end

  task automatic wait_ticks(input int n);
    repeat (n) begin
      @(posedge clk);
      while (!baud_tick) @(posedge clk);
    end
    #1;
  endtask

  task automatic send_char(input logic [7:0] d, input logic [5:0] l, input bit flip,
                           input bit stop, input bit ovr, input bit pause, input int gap);
    int n;
    logic [7:0] m;
    logic pbit;
    exp_t e;
    n = 5 + int'(l[1:0]);
    m = 8'((1 << n) - 1);
    lcr = l;
    fifo_full = ovr;
    pbit = (l[5] ? ~l[4] : l[4] ? ^(d & m) : ~^(d & m)) ^ flip;
    e.data = d & m;
    e.pe = l[3] & flip;
    e.fe = ~stop;
    e.bi = (d & m) == 8'h00 && (!l[3] || !pbit) && !stop;
    e.ovr = ovr;
    e.ticks = 8 + 16 * (1 + n + int'(l[3]));
    q.push_back(e);
    sin = 0;
    wait_ticks(16);
    if (pause) begin
      hold = 1;
      repeat (40) @(posedge clk);
      hold = 0;
    end
    for (int i = 0; i < n; i++) begin
      sin = d[i];
      wait_ticks(16);
    end
    if (l[3]) begin
      sin = pbit;
      wait_ticks(16);
    end
    sin = stop;
    wait_ticks(16);
    sin = 1;
    fifo_full = 0;
    wait_ticks(gap);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    #12;
    check("reset_outputs", 32'({push, overrun, pe, fe, bi, rx_busy}), 32'd0);
    check("reset_rx_data", 32'(rx_data), 32'd0);
    @(negedge clk) rst = 0;
    wait_ticks(20);
    send_char(8'hA5, 6'b000011, 0, 1, 0, 0, 8);
    send_char(8'h16, 6'b011000, 0, 1, 0, 0, 8);
    send_char(8'h16, 6'b011000, 1, 1, 0, 0, 8);
    lcr = 6'b000011;
    repeat (3) begin
      sin = 0;
      wait_ticks(2);
      sin = 1;
      wait_ticks(14);
    end
    wait_ticks(16);
    check("false_start_idle", 32'(rx_busy), 32'd0);
    send_char(8'h3C, 6'b000011, 0, 1, 0, 0, 8);
    begin
      exp_t e;
      e.data = 8'h00; e.pe = 0; e.fe = 1; e.bi = 1; e.ovr = 0; e.ticks = 8 + 16 * 9;
      q.push_back(e);
      sin = 0;
      wait_ticks(320);
      check("held_low_idle", 32'(rx_busy), 32'd0);
      sin = 1;
      wait_ticks(20);
    end
    send_char(8'h55, 6'b000011, 0, 1, 1, 0, 8);
    send_char(8'hAA, 6'b000011, 0, 1, 0, 0, 8);
    lcr = 6'b000011;
    sin = 0;
    wait_ticks(16);
    sin = 1;
    wait_ticks(16 * 4 + 8);
    #2 rst = 1;
    #1;
    check("midchar_reset_outputs", 32'({push, overrun, pe, fe, bi, rx_busy}), 32'd0);
    check("midchar_reset_rx_data", 32'(rx_data), 32'd0);
    repeat (5) @(posedge clk);
    #1 rst = 0;
    wait_ticks(200);
    send_char(8'h81, 6'b000011, 0, 1, 0, 0, 8);
    for (int k = 0; k < 40; k++) begin
      logic [5:0] l;
      l = 6'($urandom_range(0, 63));
      send_char(8'($urandom_range(0, 255)), l, l[3] & 1'($urandom_range(0, 1)),
                $urandom_range(0, 7) != 0, $urandom_range(0, 9) == 0,
                $urandom_range(0, 5) == 0, $urandom_range(1, 20));
    end
    for (int i = 0; i < 4000 && q.size() != 0; i++) @(posedge clk);
    check("drain", 32'(q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
